// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch queue bundle: redirect, imem and decode-side handshake
interface if_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [ILEN-1:0] imem_rdata_i;
    logic            id_valid_o;
    logic            id_ready_i;
    logic [ILEN-1:0] id_instr_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_pcp4_o;
    logic [CW-1:0]   fifo_count_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_rdata_i, id_ready_i,
        output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pcp4_o,
               fifo_count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_rdata_i, id_ready_i,
        input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pcp4_o,
               fifo_count_o
    );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with PC and DEPTH-entry prefetch FIFO
module if_fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              PC_INC    = 4,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_queue_if.master   fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;
    logic [XLEN-1:0] redirect_target;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] last_pcp4;
    logic            nonempty;
    logic            push;
    logic            pop;

    logic [ILEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_pcp4  [DEPTH];

    always_comb begin
        pc_next_seq     = pc + XLEN'(PC_INC);
        redirect_target = fq.redirect_pc_i & ~XLEN'(3);
        nonempty        = (count != '0);
        pop             = nonempty && fq.id_ready_i && !fq.redirect_i;
        // A full queue may still fetch when the head leaves in the same cycle.
        push            = rst && !fq.redirect_i && ((count < CW'(DEPTH)) || pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= fq.imem_rdata_i;
            mem_pc[wr_ptr]    <= pc;
            mem_pcp4[wr_ptr]  <= pc_next_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_pc   <= '0;
            last_pcp4 <= '0;
        end else begin
            // Remember the presented head so pc/pcp4 outputs hold once the queue drains.
            if (nonempty) begin
                last_pc   <= mem_pc[rd_ptr];
                last_pcp4 <= mem_pcp4[rd_ptr];
            end
            if (fq.redirect_i) begin
                pc     <= redirect_target;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc_next_seq;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_comb begin
        fq.imem_req_o   = push;
        fq.imem_addr_o  = pc;
        fq.fifo_count_o = count;
        fq.id_valid_o   = nonempty && !fq.redirect_i;
        fq.id_instr_o   = NOP_INSTR;
        fq.id_pc_o      = last_pc;
        fq.id_pcp4_o    = last_pcp4;
        if (nonempty) begin
            fq.id_pc_o   = mem_pc[rd_ptr];
            fq.id_pcp4_o = mem_pcp4[rd_ptr];
        end
        if (fq.id_valid_o) begin
            fq.id_instr_o = mem_instr[rd_ptr];
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed bench for if_fetch_queue
module tb_if_fetch_queue;
    localparam logic [31:0] TAG = 32'hA5A50000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    if_fetch_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) fq ();
    if_fetch_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) fq_b ();

    assign fq.imem_rdata_i   = fq.imem_addr_o ^ TAG;
    assign fq_b.imem_rdata_i = fq_b.imem_addr_o ^ TAG;

    if_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
    );

    if_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'hFFFFFFF8)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .fq  (fq_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        rst_b = 1'b0;
        fq.id_ready_i = 1'b1;
        fq.redirect_i = 1'b0;
        fq.redirect_pc_i = '0;
        fq_b.id_ready_i = 1'b1;
        fq_b.redirect_i = 1'b0;
        fq_b.redirect_pc_i = '0;

        cyc();
        cyc();
        chk("rst_valid", 32'(fq.id_valid_o), 32'd0);
        chk("rst_instr", fq.id_instr_o, NOP);
        chk("rst_pc", fq.id_pc_o, 32'h0);
        chk("rst_pcp4", fq.id_pcp4_o, 32'h0);
        chk("rst_count", 32'(fq.fifo_count_o), 32'd0);
        chk("rst_req", 32'(fq.imem_req_o), 32'd0);
        chk("rst_addr", fq.imem_addr_o, 32'h0);
        chk("rstb_addr", fq_b.imem_addr_o, 32'hFFFFFFF8);
        chk("rstb_valid", 32'(fq_b.id_valid_o), 32'd0);

        // Streaming with decode always ready.
        rst = 1'b1;
        #1;
        chk("rel_req", 32'(fq.imem_req_o), 32'd1);
        chk("rel_addr", fq.imem_addr_o, 32'h0);
        cyc();
        chk("s0_valid", 32'(fq.id_valid_o), 32'd1);
        chk("s0_pc", fq.id_pc_o, 32'h0);
        chk("s0_pcp4", fq.id_pcp4_o, 32'h4);
        chk("s0_instr", fq.id_instr_o, TAG);
        chk("s0_count", 32'(fq.fifo_count_o), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("s_pc", fq.id_pc_o, 32'(4 * k));
            chk("s_instr", fq.id_instr_o, 32'(4 * k) ^ TAG);
            chk("s_count", 32'(fq.fifo_count_o), 32'd1);
        end

        // Stall from reset until full, then drain with concurrent refill.
        rst = 1'b0;
        fq.id_ready_i = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("fill_count", 32'(fq.fifo_count_o), 32'(i));
        end
        chk("full_req", 32'(fq.imem_req_o), 32'd0);
        chk("full_addr", fq.imem_addr_o, 32'h10);
        cyc();
        cyc();
        chk("hold_count", 32'(fq.fifo_count_o), 32'd4);
        chk("hold_addr", fq.imem_addr_o, 32'h10);
        chk("hold_pc", fq.id_pc_o, 32'h0);
        fq.id_ready_i = 1'b1;
        #1;
        chk("full_pop_req", 32'(fq.imem_req_o), 32'd1);
        for (int j = 0; j < 8; j++) begin
            chk("drain_pc", fq.id_pc_o, 32'(4 * j));
            chk("drain_valid", 32'(fq.id_valid_o), 32'd1);
            chk("drain_count", 32'(fq.fifo_count_o), 32'd4);
            cyc();
        end

        // Redirect with three entries queued.
        rst = 1'b0;
        fq.id_ready_i = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("pre_rd_count", 32'(fq.fifo_count_o), 32'd3);
        chk("pre_rd_valid", 32'(fq.id_valid_o), 32'd1);
        fq.redirect_i = 1'b1;
        fq.redirect_pc_i = 32'h00000103;
        #1;
        chk("rd_valid", 32'(fq.id_valid_o), 32'd0);
        chk("rd_req", 32'(fq.imem_req_o), 32'd0);
        cyc();
        fq.redirect_i = 1'b0;
        #1;
        chk("rd1_count", 32'(fq.fifo_count_o), 32'd0);
        chk("rd1_valid", 32'(fq.id_valid_o), 32'd0);
        chk("rd1_addr", fq.imem_addr_o, 32'h100);
        fq.id_ready_i = 1'b1;
        cyc();
        chk("rd2_valid", 32'(fq.id_valid_o), 32'd1);
        chk("rd2_pc", fq.id_pc_o, 32'h100);
        chk("rd2_pcp4", fq.id_pcp4_o, 32'h104);
        chk("rd2_instr", fq.id_instr_o, 32'h100 ^ TAG);
        cyc();
        chk("rd3_pc", fq.id_pc_o, 32'h104);

        // Back-to-back redirects: the second one wins.
        fq.redirect_i = 1'b1;
        fq.redirect_pc_i = 32'h200;
        cyc();
        fq.redirect_pc_i = 32'h306;
        cyc();
        fq.redirect_i = 1'b0;
        #1;
        chk("b2b_addr", fq.imem_addr_o, 32'h304);
        chk("b2b_count", 32'(fq.fifo_count_o), 32'd0);
        cyc();
        chk("b2b_pc", fq.id_pc_o, 32'h304);
        chk("b2b_valid", 32'(fq.id_valid_o), 32'd1);
        chk("b2b_cnt1", 32'(fq.fifo_count_o), 32'd1);

        // Reset overrides a simultaneous redirect.
        rst = 1'b0;
        fq.id_ready_i = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        chk("pre_rst_count", 32'(fq.fifo_count_o), 32'd2);
        rst = 1'b0;
        fq.redirect_i = 1'b1;
        fq.redirect_pc_i = 32'h500;
        #1;
        chk("rr_req", 32'(fq.imem_req_o), 32'd0);
        cyc();
        chk("rr_count", 32'(fq.fifo_count_o), 32'd0);
        chk("rr_valid", 32'(fq.id_valid_o), 32'd0);
        chk("rr_addr", fq.imem_addr_o, 32'h0);
        chk("rr_req2", 32'(fq.imem_req_o), 32'd0);
        fq.redirect_i = 1'b0;
        rst = 1'b1;
        fq.id_ready_i = 1'b1;
        cyc();
        chk("rr_head_pc", fq.id_pc_o, 32'h0);
        chk("rr_head_valid", 32'(fq.id_valid_o), 32'd1);

        // PC wrap past the top of the address space.
        rst_b = 1'b1;
        cyc();
        chk("w0_pc", fq_b.id_pc_o, 32'hFFFFFFF8);
        chk("w0_pcp4", fq_b.id_pcp4_o, 32'hFFFFFFFC);
        cyc();
        chk("w1_pc", fq_b.id_pc_o, 32'hFFFFFFFC);
        chk("w1_pcp4", fq_b.id_pcp4_o, 32'h0);
        chk("w1_instr", fq_b.id_instr_o, 32'hFFFFFFFC ^ TAG);
        cyc();
        chk("w2_pc", fq_b.id_pc_o, 32'h0);
        chk("w2_pcp4", fq_b.id_pcp4_o, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
